// File: rtl/neuron_argmax.sv
// Running argmax over a frame of NUM_NEURONS signed Q8.8 scores, with the result held on a valid/ready port.
// Optional NEURON_ARGMAX_RELU_EN clamps negative scores to zero before they are compared and stored.
module neuron_argmax #(
   parameter int NUM_NEURONS = 10,
   parameter int DATA_WIDTH  = 16,
   parameter int IDX_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IDX_WIDTH-1:0]  out_class,
   output logic [DATA_WIDTH-1:0] out_score,
   output logic                  frame_err
);

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

   state_t                        state, state_nxt;
   logic [IDX_WIDTH-1:0]          cnt, max_idx, idx_nxt;
   logic signed [DATA_WIDTH-1:0]  max_val, val_nxt, score;
   logic                          accept, is_first, is_last;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid & in_ready;
   assign is_first  = (cnt == '0);
   assign is_last   = (cnt == LAST_IDX);

`ifdef NEURON_ARGMAX_RELU_EN
   assign score = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
   assign score = in_data;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (accept && is_last) state_nxt = HOLD;
         HOLD:    if (out_ready)         state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   // Strict greater-than so a tie leaves the earlier index as winner.
   always_comb begin
      val_nxt = max_val;
      idx_nxt = max_idx;
      if (is_first) begin
         val_nxt = score;
         idx_nxt = '0;
      end else if (score > max_val) begin
         val_nxt = score;
         idx_nxt = cnt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ACCUM;
         cnt       <= '0;
         max_val   <= '0;
         max_idx   <= '0;
         out_class <= '0;
         out_score <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_err <= accept & (in_last != is_last);
         if (accept) begin
            max_val <= val_nxt;
            max_idx <= idx_nxt;
            cnt     <= is_last ? '0 : cnt + IDX_WIDTH'(1);
            // Publish the winner including this beat's own compare.
            if (is_last) begin
               out_class <= idx_nxt;
               out_score <= val_nxt;
            end
         end
      end
   end

endmodule

// File: doc/neuron_argmax.md
# neuron_argmax

Classification stage downstream of the output-layer MAC units. It accepts one 16-bit Q8.8 neuron score per handshake, tracks the running maximum across a frame of `NUM_NEURONS` scores, and presents the winning neuron index and its score on a held valid/ready output. Framing is by internal count; an `in_last` marker is checked against that count and flagged on mismatch.

## Interface
- `NUM_NEURONS`, 10: scores per frame, ≥ 2.
- `DATA_WIDTH`, 16: score width, signed two's complement Q8.8.
- `IDX_WIDTH`, 4: index width, must satisfy 2^`IDX_WIDTH` ≥ `NUM_NEURONS`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a score.
- `in_data`  in  `DATA_WIDTH`  signed neuron score (`mac_out` of neuron *k*).
- `in_last`  in  1  upstream marks the final score of a frame.
- `out_valid`  out  1  result is available.
- `out_ready`  in  1  consumer takes the result.
- `out_class`  out  `IDX_WIDTH`  index of the winning neuron.
- `out_score`  out  `DATA_WIDTH`  score of the winning neuron.
- `frame_err`  out  1  one-cycle pulse when `in_last` disagrees with the count.

## Operation
- States:
  - `ACCUM`: `in_ready`=1.
  - `HOLD`: `in_ready`=0, `out_valid`=1.
- An input beat is accepted when `in_valid & in_ready`.
- Registers:
  - `cnt`, range 0..`NUM_NEURONS`-1.
  - `max_val`, `DATA_WIDTH` bits.
  - `max_idx`, `IDX_WIDTH` bits.
- Accepted beat with `cnt`==0: load `max_val`=`in_data` and `max_idx`=0 unconditionally.
- Accepted beat with `cnt`>0:
  - Signed compare, full `DATA_WIDTH`.
  - If `in_data` > `max_val` (strict), load `max_val`=`in_data` and `max_idx`=`cnt`.
  - Ties keep the lower index.
- `cnt` increments on every accepted beat.
- Accepted beat with `cnt`==`NUM_NEURONS`-1:
  - `cnt` wraps to 0.
  - State goes to `HOLD`.
  - `out_class`/`out_score` are loaded with the final winner, including the current beat's compare.
- `HOLD`: outputs are stable while `out_valid & !out_ready`. On `out_valid & out_ready`, state goes to `ACCUM`.
- Framing check on each accepted beat:
  - `frame_err`=1 next cycle if `in_last` ≠ (`cnt`==`NUM_NEURONS`-1), otherwise 0.
  - The count governs framing; an error does not truncate or extend the frame.
- `in_valid` while in `HOLD`: not accepted. Upstream holds the data, which is accepted after return to `ACCUM`.
- Reset values (asynchronous, on `reset`=0):
  - state=`ACCUM`, `in_ready`=1.
  - `cnt`=0, `max_val`=0, `max_idx`=0.
  - `out_valid`=0, `out_class`=0, `out_score`=0, `frame_err`=0.
- Reset mid-frame discards partial accumulation. The next accepted beat is index 0.

## Timing
- `in_ready` is a combinational decode of state only. It does not depend on `out_ready`, so there is no ready-through path.
- Throughput: one score per cycle while in `ACCUM`.
- Latency: last beat accepted at edge *t* → `out_valid`=1 after edge *t* (visible in cycle *t*+1).
- Output consumed at edge *u* → `in_ready`=1 in cycle *u*+1. There is no same-cycle bypass, so the minimum frame period is `NUM_NEURONS`+1 cycles.
- `frame_err` is registered, asserted for exactly one cycle after the offending beat.
- `out_class`/`out_score` retain their last value after handshake until the next frame completes.

## Configuration
- `NEURON_ARGMAX_RELU_EN` defined:
  - Each accepted `in_data` is clamped to 0 if negative before compare and store.
  - `out_score` is ≥ 0.
  - An all-negative frame yields `out_class`=0, `out_score`=0.
- Not defined: raw signed compare. `out_score` may be negative.

## Test plan
- Reset then frame {1,5,3,9,2,0,7,9,4,8} (integer Q8.8 values), `in_last` on beat 9, `out_ready`=1 → `out_valid` one cycle after beat 9; `out_class`=3 (tie with index 7 keeps 3), `out_score`=0x0900; `frame_err` never set.
- Frame with maximum on last beat (index 9 = 0x7FFF, others 0x0100) → `out_class`=9, `out_score`=0x7FFF; same-cycle compare included.
- Back-pressure: `out_ready`=0 for 5 cycles after completion with `in_valid`=1 held → `in_ready`=0, outputs stable; `out_ready`=1 → next cycle `in_ready`=1, held beat accepted as index 0.
- All-negative frame (−1.0 = 0xFF00 … −10.0 = 0xF600 descending) → without macro `out_class`=0, `out_score`=0xFF00; with `NEURON_ARGMAX_RELU_EN` `out_class`=0, `out_score`=0.
- `in_last` on beat 4, not on beat 9 → `frame_err` pulses after beat 4 and after beat 9; result still presented after beat 9.
- Assert `reset`=0 after 6 beats, release, send a full frame with max at index 2 → `out_class`=2; no result from the aborted frame.
